// File: rtl/cfg_loader_pkg.sv
// Shared constants and FSM state type for the SPI configuration loader.
// Command codes select whether a received word is deferred or applied at once.
package cfg_loader_pkg;

  localparam int CFG_BYTES = 4;
  localparam logic [31:0] RESET_CFG = 32'hBBFC_0000;

  localparam logic [7:0] CMD_WR_DEFER = 8'hC1;
  localparam logic [7:0] CMD_WR_NOW   = 8'hC2;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    DONE,
    DISCARD
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// RESET_VAL sets both flops so the output is quiet when reset releases.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      dout     <= RESET_VAL;
    end else begin
      meta_reg <= din;
      dout     <= meta_reg;
    end
  end

endmodule

// File: rtl/spi_config_loader.sv
// Assembles a framed SPI write (command + 4 bytes, MSB first) into the
// configuration word, applied immediately or at the next frame tick.
module spi_config_loader #(
  parameter int                CFG_W     = 8 * cfg_loader_pkg::CFG_BYTES,
  parameter logic [CFG_W-1:0]  RESET_CFG = cfg_loader_pkg::RESET_CFG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             ss_n,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  input  logic             frame_tick,
  input  logic             err_clear,
  output logic [CFG_W-1:0] config_out,
  output logic             pending,
  output logic             err
);

  import cfg_loader_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(CFG_BYTES - 1);

  logic             ss_sync;
  logic             ss_act;
  state_t           state_reg;
  logic             mode_now_reg;
  logic [1:0]       count_reg;
  logic [CFG_W-9:0] acc_reg;
  logic [CFG_W-1:0] shadow_reg;
  logic [CFG_W-1:0] word;

  // The synchronizer keeps running while ena is low so ss state stays fresh.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_ss_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ss_n),
    .dout  (ss_sync)
  );

  assign ss_act = ~ss_sync;
  assign word   = {acc_reg, rx_byte};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      mode_now_reg <= 1'b0;
      count_reg    <= '0;
      acc_reg      <= '0;
      shadow_reg   <= RESET_CFG;
      config_out   <= RESET_CFG;
      pending      <= 1'b0;
      err          <= 1'b0;
    end else if (ena) begin
      // Later assignments below override these, so error sets beat clears
      // and a completing write beats the frame tick.
      if (err_clear)
        err <= 1'b0;
      if (frame_tick && pending) begin
        config_out <= shadow_reg;
        pending    <= 1'b0;
      end

      if (!ss_act) begin
        if (state_reg == CMD || state_reg == DATA)
          err <= 1'b1;
        acc_reg   <= '0;
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: state_reg <= CMD;
          CMD: begin
            if (rx_valid) begin
              if (rx_byte == CMD_WR_DEFER || rx_byte == CMD_WR_NOW) begin
                mode_now_reg <= (rx_byte == CMD_WR_NOW);
                count_reg    <= '0;
                state_reg    <= DATA;
              end else begin
                err       <= 1'b1;
                state_reg <= DISCARD;
              end
            end
          end
          DATA: begin
            if (rx_valid) begin
              acc_reg   <= word[CFG_W-9:0];
              count_reg <= count_reg + 2'd1;
              if (count_reg == LAST_IDX) begin
                shadow_reg <= word;
                state_reg  <= DONE;
                if (mode_now_reg) begin
                  config_out <= word;
                  pending    <= 1'b0;
                end else begin
                  pending <= 1'b1;
                end
              end
            end
          end
          DONE: begin
            if (rx_valid)
              err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
